// File: rtl/food_vend_if.sv
`default_nettype none
// ============================================================================
// Module      : food_vend_if
// Description : Bundle of coin, selection, refill, dispenser and status
//               signals between a vending front-end and food_vend_ctrl.
//               master = front-end / environment, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface food_vend_if #(
    parameter int N_ITEMS  = 4,
    parameter int CREDIT_W = 8,
    parameter int ID_W     = 2
);
    logic                          coin_valid;
    logic [1:0]                    coin_val;
    logic                          sel_valid;
    logic [ID_W-1:0]               sel_id;
    logic                          cancel;
    logic [N_ITEMS*CREDIT_W-1:0]   prices;
    logic                          refill;
    logic [ID_W-1:0]               refill_id;
    logic                          vend_ready;
    logic [CREDIT_W-1:0]           credit;
    logic                          vend_valid;
    logic [ID_W-1:0]               vend_id;
    logic                          change_pulse;
    logic                          coin_reject;
    logic                          err_soldout;
    logic                          err_funds;
    logic                          busy;
    logic [N_ITEMS-1:0]            stock_empty;

    modport master (
        output coin_valid, coin_val, sel_valid, sel_id, cancel, prices,
               refill, refill_id, vend_ready,
        input  credit, vend_valid, vend_id, change_pulse, coin_reject,
               err_soldout, err_funds, busy, stock_empty
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_id, cancel, prices,
               refill, refill_id, vend_ready,
        output credit, vend_valid, vend_id, change_pulse, coin_reject,
               err_soldout, err_funds, busy, stock_empty
    );
endinterface
`default_nettype wire

// File: rtl/food_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : food_vend_ctrl
// Description : Coin-operated food vending controller. Accumulates credit,
//               validates selections against per-slot stock and price,
//               hands a vend request to the dispenser and pays change out
//               one unit per cycle.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - food_vend_if.slave (coin/select/cancel/refill
//                        strobes, static prices, dispenser handshake,
//                        registered credit/vend/change/error/status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module food_vend_ctrl #(
    parameter int N_ITEMS  = 4,
    parameter int CREDIT_W = 8,
    parameter int STOCK_W  = 4,
    parameter int ID_W     = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    food_vend_if.slave    bus
);
    localparam logic [STOCK_W-1:0]  c_STOCK_FULL = '1;
    localparam logic [CREDIT_W-1:0] c_ONE        = CREDIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CREDIT_W-1:0]    r_credit;
    logic                   r_vend_valid;
    logic [ID_W-1:0]        r_vend_id;
    logic                   r_change_pulse;
    logic                   r_coin_reject;
    logic                   r_err_soldout;
    logic                   r_err_funds;
    logic                   r_busy;
    logic [N_ITEMS-1:0]     r_stock_empty;
    logic [STOCK_W-1:0]     r_stock [N_ITEMS];

    logic [STOCK_W-1:0]     w_stock_nxt [N_ITEMS];
    logic [CREDIT_W-1:0]    w_price;
    logic [STOCK_W-1:0]     w_sel_stock;
    logic [CREDIT_W:0]      w_coin_amt;
    logic [CREDIT_W:0]      w_coin_sum;
    logic                   w_idle;
    logic                   w_sel_take;
    logic                   w_soldout;
    logic                   w_funds;
    logic                   w_vend_go;
    logic                   w_coin_ok;
    logic                   w_cancel_go;

    // Out-of-range ids match no slot, so they read back as zero stock and
    // are reported as sold out.
    always_comb begin
        w_price     = '0;
        w_sel_stock = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (int'(bus.sel_id) == i) begin
                w_price     = bus.prices[i*CREDIT_W +: CREDIT_W];
                w_sel_stock = r_stock[i];
            end
        end
    end

    always_comb begin
        case (bus.coin_val)
            2'd0:    w_coin_amt = (CREDIT_W+1)'(1);
            2'd1:    w_coin_amt = (CREDIT_W+1)'(2);
            2'd2:    w_coin_amt = (CREDIT_W+1)'(5);
            default: w_coin_amt = (CREDIT_W+1)'(10);
        endcase
    end

    // Extra carry bit detects a coin that would overflow the credit register.
    assign w_coin_sum  = {1'b0, r_credit} + w_coin_amt;
    assign w_idle      = (r_state == S_IDLE);
    // Any cancel strobe in IDLE occupies the top priority slot, even when
    // there is no credit to refund.
    assign w_sel_take  = w_idle && bus.sel_valid && !bus.cancel;
    assign w_soldout   = w_sel_take && (w_sel_stock == '0);
    assign w_funds     = w_sel_take && (w_sel_stock != '0) && (r_credit < w_price);
    assign w_vend_go   = w_sel_take && (w_sel_stock != '0) && (r_credit >= w_price);
    assign w_coin_ok   = w_idle && bus.coin_valid && !bus.cancel && !bus.sel_valid
                         && !w_coin_sum[CREDIT_W];
    assign w_cancel_go = w_idle && bus.cancel && (r_credit != '0);

    // Refill is applied after the vend decrement so it wins on a collision.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            w_stock_nxt[i] = r_stock[i];
            if (w_vend_go && int'(bus.sel_id) == i)
                w_stock_nxt[i] = r_stock[i] - STOCK_W'(1);
            if (bus.refill && int'(bus.refill_id) == i)
                w_stock_nxt[i] = c_STOCK_FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_vend_valid   <= 1'b0;
            r_vend_id      <= '0;
            r_change_pulse <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_err_soldout  <= 1'b0;
            r_err_funds    <= 1'b0;
            r_busy         <= 1'b0;
            r_stock_empty  <= '0;
            for (int i = 0; i < N_ITEMS; i++)
                r_stock[i] <= c_STOCK_FULL;
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                r_stock[i]       <= w_stock_nxt[i];
                r_stock_empty[i] <= (w_stock_nxt[i] == '0);
            end
            r_coin_reject  <= bus.coin_valid && !w_coin_ok;
            r_err_soldout  <= w_soldout;
            r_err_funds    <= w_funds;
            r_change_pulse <= 1'b0;

            // The first change unit is paid on the edge that enters CHANGE,
            // so credit N yields exactly N pulses.
            case (r_state)
                S_IDLE: begin
                    if (w_cancel_go) begin
                        r_state        <= S_CHANGE;
                        r_busy         <= 1'b1;
                        r_change_pulse <= 1'b1;
                        r_credit       <= r_credit - c_ONE;
                    end else if (w_vend_go) begin
                        r_state      <= S_VEND;
                        r_busy       <= 1'b1;
                        r_credit     <= r_credit - w_price;
                        r_vend_valid <= 1'b1;
                        r_vend_id    <= bus.sel_id;
                    end else if (w_coin_ok) begin
                        r_credit <= w_coin_sum[CREDIT_W-1:0];
                    end
                end
                S_VEND: begin
                    if (bus.vend_ready) begin
                        r_vend_valid <= 1'b0;
                        if (r_credit != '0) begin
                            r_state        <= S_CHANGE;
                            r_change_pulse <= 1'b1;
                            r_credit       <= r_credit - c_ONE;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_CHANGE: begin
                    if (r_credit != '0) begin
                        r_change_pulse <= 1'b1;
                        r_credit       <= r_credit - c_ONE;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_vend_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.credit       = r_credit;
    assign bus.vend_valid   = r_vend_valid;
    assign bus.vend_id      = r_vend_id;
    assign bus.change_pulse = r_change_pulse;
    assign bus.coin_reject  = r_coin_reject;
    assign bus.err_soldout  = r_err_soldout;
    assign bus.err_funds    = r_err_funds;
    assign bus.busy         = r_busy;
    assign bus.stock_empty  = r_stock_empty;
endmodule
`default_nettype wire

// File: tb/tb_food_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_food_vend_ctrl
// Description : Directed self-checking bench for food_vend_ctrl with four
//               slots priced {3,5,7,10}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_food_vend_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   n_chg;

    food_vend_if #(.N_ITEMS(4), .CREDIT_W(8), .ID_W(2)) bus ();

    food_vend_ctrl #(.N_ITEMS(4), .CREDIT_W(8), .STOCK_W(4), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic coin(input int v);
        @(negedge clk);
        bus.coin_valid = 1'b1;
        case (v)
            1:       bus.coin_val = 2'd0;
            2:       bus.coin_val = 2'd1;
            5:       bus.coin_val = 2'd2;
            default: bus.coin_val = 2'd3;
        endcase
        @(negedge clk);
        bus.coin_valid = 1'b0;
    endtask

    task automatic sel(input int id);
        @(negedge clk);
        bus.sel_valid = 1'b1;
        bus.sel_id    = 2'(id);
        @(negedge clk);
        bus.sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
    endtask

    task automatic do_refill(input int id);
        @(negedge clk);
        bus.refill    = 1'b1;
        bus.refill_id = 2'(id);
        @(negedge clk);
        bus.refill = 1'b0;
    endtask

    task automatic vend_ack();
        @(negedge clk);
        bus.vend_ready = 1'b1;
        @(negedge clk);
        bus.vend_ready = 1'b0;
    endtask

    // Counts consecutive change pulses starting at the current sample point.
    task automatic count_change(output int n);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            if (!bus.change_pulse) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n          = 1'b0;
        bus.coin_valid = 1'b0;
        bus.coin_val   = 2'd0;
        bus.sel_valid  = 1'b0;
        bus.sel_id     = 2'd0;
        bus.cancel     = 1'b0;
        bus.refill     = 1'b0;
        bus.refill_id  = 2'd0;
        bus.vend_ready = 1'b0;
        bus.prices     = {8'd10, 8'd7, 8'd5, 8'd3};

        repeat (3) @(negedge clk);
        check_val("rst_credit", bus.credit, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_vend_valid", bus.vend_valid, 0);
        check_val("rst_stock_empty", bus.stock_empty, 0);
        check_val("rst_change", bus.change_pulse, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact-price purchase, no change
        coin(5);
        coin(2);
        check_val("coins_5_2_credit", bus.credit, 7);
        sel(2);
        check_val("sel2_vend_valid", bus.vend_valid, 1);
        check_val("sel2_vend_id", bus.vend_id, 2);
        check_val("sel2_credit", bus.credit, 0);
        check_val("sel2_busy", bus.busy, 1);
        repeat (2) @(negedge clk);
        check_val("vend_hold_valid", bus.vend_valid, 1);
        check_val("vend_hold_id", bus.vend_id, 2);
        vend_ack();
        check_val("ack_vend_valid", bus.vend_valid, 0);
        check_val("ack_busy", bus.busy, 0);
        check_val("ack_no_change", bus.change_pulse, 0);

        // Purchase with change: 10 - 3 = 7 pulses
        coin(10);
        sel(0);
        check_val("sel0_credit", bus.credit, 7);
        check_val("sel0_vend_id", bus.vend_id, 0);
        vend_ack();
        count_change(n_chg);
        check_val("change7_count", n_chg, 7);
        check_val("change7_credit", bus.credit, 0);
        check_val("change7_busy", bus.busy, 0);

        // Credit exactly equal to price is enough
        coin(2);
        coin(1);
        sel(0);
        check_val("exact_price_vend", bus.vend_valid, 1);
        check_val("exact_price_credit", bus.credit, 0);
        vend_ack();

        // Insufficient funds then cancel refund
        coin(2);
        coin(2);
        sel(1);
        check_val("funds_err", bus.err_funds, 1);
        check_val("funds_credit", bus.credit, 4);
        check_val("funds_busy", bus.busy, 0);
        @(negedge clk);
        check_val("funds_err_pulse", bus.err_funds, 0);
        do_cancel();
        count_change(n_chg);
        check_val("cancel_count", n_chg, 4);
        check_val("cancel_credit", bus.credit, 0);

        // Drain slot 3, sold-out, refill
        for (int i = 0; i < 15; i++) begin
            coin(10);
            sel(3);
            vend_ack();
            if (i == 13) check_val("stock3_one_left", bus.stock_empty[3], 0);
        end
        check_val("stock3_empty", bus.stock_empty[3], 1);
        coin(10);
        sel(3);
        check_val("soldout_err", bus.err_soldout, 1);
        check_val("soldout_no_vend", bus.vend_valid, 0);
        check_val("soldout_credit", bus.credit, 10);
        do_refill(3);
        check_val("refill_stock3", bus.stock_empty[3], 0);
        do_cancel();
        count_change(n_chg);
        check_val("cancel10_count", n_chg, 10);

        // Saturation and priority
        for (int i = 0; i < 25; i++) coin(10);
        check_val("credit_250", bus.credit, 250);
        coin(10);
        check_val("sat_reject", bus.coin_reject, 1);
        check_val("sat_credit", bus.credit, 250);
        coin(5);
        check_val("fill_255_reject", bus.coin_reject, 0);
        check_val("fill_255_credit", bus.credit, 255);
        coin(1);
        check_val("over_255_reject", bus.coin_reject, 1);
        @(negedge clk);
        bus.coin_valid = 1'b1;
        bus.coin_val   = 2'd3;
        bus.sel_valid  = 1'b1;
        bus.sel_id     = 2'd0;
        @(negedge clk);
        bus.coin_valid = 1'b0;
        bus.sel_valid  = 1'b0;
        check_val("prio_coin_reject", bus.coin_reject, 1);
        check_val("prio_vend_valid", bus.vend_valid, 1);
        check_val("prio_credit", bus.credit, 252);
        coin(10);
        check_val("vend_coin_reject", bus.coin_reject, 1);
        check_val("vend_coin_credit", bus.credit, 252);
        vend_ack();
        count_change(n_chg);
        check_val("change252_count", n_chg, 252);

        // Asynchronous reset mid-CHANGE
        coin(10);
        do_cancel();
        repeat (4) @(negedge clk);
        check_val("pre_rst_credit", bus.credit, 5);
        check_val("pre_rst_change", bus.change_pulse, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_credit", bus.credit, 0);
        check_val("async_rst_change", bus.change_pulse, 0);
        check_val("async_rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("post_rst_idle", bus.busy, 0);
        check_val("post_rst_change", bus.change_pulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
